// File: rtl/motor_seq_pkg.sv
// Shared encodings for the drum motor sequencer: command modes, driver direction codes
// and FSM states.
package motor_seq_pkg;

  typedef enum logic [1:0] {
    CMD_STOP   = 2'b00,
    CMD_AGI_LO = 2'b01,
    CMD_AGI_HI = 2'b10,
    CMD_SPIN   = 2'b11
  } cmd_mode_e;

  localparam logic [1:0] DIR_OFF = 2'b00;
  localparam logic [1:0] DIR_CW  = 2'b01;
  localparam logic [1:0] DIR_CCW = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN_CW,
    ST_RUN_CCW,
    ST_BRAKE,
    ST_SPIN,
    ST_HOLD,
    ST_FAULT
  } state_e;

  function automatic logic is_agi(input cmd_mode_e m);
    return (m == CMD_AGI_LO) || (m == CMD_AGI_HI);
  endfunction

endpackage

// File: rtl/motor_drive_sequencer_if.sv
// Command handshake, safety inputs and motor driver outputs between the wash FSM
// (master) and the motor sequencer (slave).
interface motor_drive_sequencer_if #(
  parameter int PWM_BITS = 8
);
  logic                cmd_valid;
  logic [1:0]          cmd_mode;
  logic                cmd_ready;
  logic                door_closed;
  logic                pause;
  logic                motor_en;
  logic [1:0]          motor_dir;
  logic [PWM_BITS-1:0] duty;
  logic                pwm_out;
  logic                busy;
  logic                fault;

  modport master (
    output cmd_valid, cmd_mode, door_closed, pause,
    input  cmd_ready, motor_en, motor_dir, duty, pwm_out, busy, fault
  );

  modport slave (
    input  cmd_valid, cmd_mode, door_closed, pause,
    output cmd_ready, motor_en, motor_dir, duty, pwm_out, busy, fault
  );
endinterface

// File: rtl/motor_pwm_gen.sv
// Free-running PWM counter with a registered compare against the current duty;
// output is forced low whenever the motor is disabled.
module motor_pwm_gen #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_en,
  input  logic [PWM_BITS-1:0] i_duty,
  output logic                o_pwm
);

  logic [PWM_BITS-1:0] r_cnt;
  logic                r_pwm;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_pwm <= 1'b0;
    end else begin
      r_cnt <= r_cnt + PWM_BITS'(1);
      r_pwm <= i_en && (r_cnt < i_duty);
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/motor_drive_sequencer.sv
// Drum motor sequencer: turns wash-FSM motor commands into enable/direction/duty with
// reversal dead-time, spin ramp, pause hold and door interlock.
module motor_drive_sequencer
  import motor_seq_pkg::*;
#(
  parameter int AGI_ON_CYC  = 2_000_000,
  parameter int DEAD_CYC    = 500_000,
  parameter int RAMP_CYC    = 250_000,
  parameter int PWM_BITS    = 8,
  parameter int AGI_DUTY_LO = 96,
  parameter int AGI_DUTY_HI = 192,
  parameter int DUTY_STEP   = 16,
  parameter int SPIN_MAX    = 255
) (
  input logic                    clk,
  input logic                    reset,
  motor_drive_sequencer_if.slave bus
);

  localparam int CNT_MAX0 = (AGI_ON_CYC > DEAD_CYC) ? AGI_ON_CYC : DEAD_CYC;
  localparam int CNT_MAX  = (CNT_MAX0 > RAMP_CYC) ? CNT_MAX0 : RAMP_CYC;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]    AGI_LAST  = CNT_W'(AGI_ON_CYC - 1);
  localparam logic [CNT_W-1:0]    DEAD_LAST = CNT_W'(DEAD_CYC - 1);
  localparam logic [CNT_W-1:0]    RAMP_LAST = CNT_W'(RAMP_CYC - 1);
  localparam logic [PWM_BITS-1:0] DUTY_LO   = PWM_BITS'(AGI_DUTY_LO);
  localparam logic [PWM_BITS-1:0] DUTY_HI   = PWM_BITS'(AGI_DUTY_HI);
  localparam logic [PWM_BITS-1:0] DUTY_1ST  = PWM_BITS'(DUTY_STEP);

  // One extra bit of headroom so the ramp clamps at the ceiling instead of wrapping.
  function automatic logic [PWM_BITS-1:0] spin_next(input logic [PWM_BITS-1:0] d);
    logic [PWM_BITS:0] s;
    s = {1'b0, d} + (PWM_BITS+1)'(DUTY_STEP);
    if (s > (PWM_BITS+1)'(SPIN_MAX)) return PWM_BITS'(SPIN_MAX);
    return s[PWM_BITS-1:0];
  endfunction

  state_e              r_state, r_target, w_state, w_target;
  cmd_mode_e           r_mode, w_mode, w_cmd;
  logic [CNT_W-1:0]    r_cnt, w_cnt, w_cnt_inc;
  logic [PWM_BITS-1:0] r_spin_duty, w_spin_duty;
  logic                r_en, r_busy, r_fault, r_rdy;
  logic                w_en, w_busy, w_fault, w_rdy, w_accept, w_pwm;
  logic [1:0]          r_dir, w_dir;
  logic [PWM_BITS-1:0] r_duty, w_duty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_target    <= ST_IDLE;
      r_mode      <= CMD_STOP;
      r_cnt       <= '0;
      r_spin_duty <= '0;
      r_en        <= 1'b0;
      r_dir       <= DIR_OFF;
      r_duty      <= '0;
      r_busy      <= 1'b0;
      r_fault     <= 1'b0;
      r_rdy       <= 1'b1;
    end else begin
      r_state     <= w_state;
      r_target    <= w_target;
      r_mode      <= w_mode;
      r_cnt       <= w_cnt;
      r_spin_duty <= w_spin_duty;
      r_en        <= w_en;
      r_dir       <= w_dir;
      r_duty      <= w_duty;
      r_busy      <= w_busy;
      r_fault     <= w_fault;
      r_rdy       <= w_rdy;
    end
  end

  always_comb begin
    w_accept    = bus.cmd_valid & r_rdy;
    w_cmd       = cmd_mode_e'(bus.cmd_mode);
    w_cnt_inc   = r_cnt + CNT_W'(1);
    w_state     = r_state;
    w_target    = r_target;
    w_mode      = r_mode;
    w_cnt       = r_cnt;
    w_spin_duty = r_spin_duty;

    case (r_state)
      ST_IDLE: begin
        if (w_accept && bus.door_closed) begin
          w_mode = w_cmd;
          w_cnt  = '0;
          case (w_cmd)
            CMD_AGI_LO, CMD_AGI_HI: w_state = ST_RUN_CW;
            CMD_SPIN: begin
              w_state     = ST_SPIN;
              w_spin_duty = DUTY_1ST;
            end
            default: ;
          endcase
        end
      end
      ST_RUN_CW, ST_RUN_CCW: begin
        if (!bus.door_closed) begin
          w_state = ST_FAULT;
          w_cnt   = '0;
        end else if (bus.pause) begin
          w_state  = ST_BRAKE;
          w_target = ST_HOLD;
          w_cnt    = '0;
        end else if (w_accept && (w_cmd == CMD_STOP || w_cmd == CMD_SPIN)) begin
          w_mode   = w_cmd;
          w_state  = ST_BRAKE;
          w_target = (w_cmd == CMD_SPIN) ? ST_SPIN : ST_IDLE;
          w_cnt    = '0;
        end else begin
          // A level change keeps the segment timer running; only the duty follows.
          if (w_accept) w_mode = w_cmd;
          if (r_cnt == AGI_LAST) begin
            w_state  = ST_BRAKE;
            w_target = (r_state == ST_RUN_CW) ? ST_RUN_CCW : ST_RUN_CW;
            w_cnt    = '0;
          end else begin
            w_cnt = w_cnt_inc;
          end
        end
      end
      ST_SPIN: begin
        if (!bus.door_closed) begin
          w_state = ST_FAULT;
          w_cnt   = '0;
        end else if (bus.pause) begin
          w_state  = ST_BRAKE;
          w_target = ST_HOLD;
          w_cnt    = '0;
        end else if (w_accept && w_cmd != CMD_SPIN) begin
          w_mode   = w_cmd;
          w_state  = ST_BRAKE;
          w_target = (w_cmd == CMD_STOP) ? ST_IDLE : ST_RUN_CW;
          w_cnt    = '0;
        end else if (r_cnt == RAMP_LAST) begin
          w_spin_duty = spin_next(r_spin_duty);
          w_cnt       = '0;
        end else begin
          w_cnt = w_cnt_inc;
        end
      end
      ST_BRAKE: begin
        if (!bus.door_closed) begin
          w_state = ST_FAULT;
          w_cnt   = '0;
        end else if (r_cnt == DEAD_LAST) begin
          w_state = r_target;
          w_cnt   = '0;
          if (r_target == ST_SPIN) w_spin_duty = DUTY_1ST;
        end else begin
          w_cnt = w_cnt_inc;
        end
      end
      ST_HOLD: begin
        if (!bus.door_closed) begin
          w_state = ST_FAULT;
          w_cnt   = '0;
        end else begin
          if (w_accept) w_mode = w_cmd;
          if (!bus.pause) begin
            w_cnt = '0;
            if (is_agi(w_mode)) begin
              w_state = ST_RUN_CW;
            end else if (w_mode == CMD_SPIN) begin
              w_state     = ST_SPIN;
              w_spin_duty = DUTY_1ST;
            end else begin
              w_state = ST_IDLE;
            end
          end
        end
      end
      ST_FAULT: begin
        if (w_accept && w_cmd == CMD_STOP && bus.door_closed) begin
          w_state = ST_IDLE;
          w_mode  = CMD_STOP;
        end
      end
      default: w_state = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they change on the same edge as the state.
    w_en    = 1'b0;
    w_dir   = DIR_OFF;
    w_duty  = '0;
    w_busy  = (w_state != ST_IDLE);
    w_fault = (w_state == ST_FAULT);
    w_rdy   = (w_state != ST_BRAKE);
    case (w_state)
      ST_RUN_CW: begin
        w_en   = 1'b1;
        w_dir  = DIR_CW;
        w_duty = (w_mode == CMD_AGI_HI) ? DUTY_HI : DUTY_LO;
      end
      ST_RUN_CCW: begin
        w_en   = 1'b1;
        w_dir  = DIR_CCW;
        w_duty = (w_mode == CMD_AGI_HI) ? DUTY_HI : DUTY_LO;
      end
      ST_SPIN: begin
        w_en   = 1'b1;
        w_dir  = DIR_CW;
        w_duty = w_spin_duty;
      end
      default: ;
    endcase
  end

  motor_pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk    (clk),
    .reset  (reset),
    .i_en   (r_en),
    .i_duty (r_duty),
    .o_pwm  (w_pwm)
  );

  assign bus.cmd_ready = r_rdy;
  assign bus.motor_en  = r_en;
  assign bus.motor_dir = r_dir;
  assign bus.duty      = r_duty;
  assign bus.pwm_out   = w_pwm;
  assign bus.busy      = r_busy;
  assign bus.fault     = r_fault;

endmodule

// File: tb/tb_motor_drive_sequencer.sv
// Bench for motor_drive_sequencer: table-driven agitate/spin vectors, hand-written corner
// sequences, then random stimulus against a countdown-based behavioural model.
module tb_motor_drive_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  motor_drive_sequencer_if #(.PWM_BITS(8)) bus ();

  motor_drive_sequencer #(
    .AGI_ON_CYC (8), .DEAD_CYC (3), .RAMP_CYC (4), .PWM_BITS (8),
    .AGI_DUTY_LO (96), .AGI_DUTY_HI (192), .DUTY_STEP (64), .SPIN_MAX (255)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic v; logic [1:0] m; logic door; logic pz; logic r;
    int en; int dir; int duty; int busy; int rdy; int flt;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic v, input logic [1:0] m, input logic door, input logic pz,
                     input logic r, input int en, input int dir, input int duty,
                     input int busy, input int rdy, input int flt);
    vec_t x;
    x.v = v; x.m = m; x.door = door; x.pz = pz; x.r = r;
    x.en = en; x.dir = dir; x.duty = duty; x.busy = busy; x.rdy = rdy; x.flt = flt;
    tbl.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int en, input int dir, input int duty,
                         input int busy, input int rdy, input int flt);
    chk({tag, ".en"},    32'(bus.motor_en),  en);
    chk({tag, ".dir"},   32'(bus.motor_dir), dir);
    chk({tag, ".duty"},  32'(bus.duty),      duty);
    chk({tag, ".busy"},  32'(bus.busy),      busy);
    chk({tag, ".ready"}, 32'(bus.cmd_ready), rdy);
    chk({tag, ".fault"}, 32'(bus.fault),     flt);
  endtask

  // Apply inputs, let one active edge pass, sample 1 time unit later.
  task automatic cyc(input logic v, input logic [1:0] m, input logic door, input logic pz,
                     input logic r);
    bus.cmd_valid = v; bus.cmd_mode = m; bus.door_closed = door; bus.pause = pz; reset = r;
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: what the motor is doing plus remaining-time countdowns.
  localparam int K_IDLE = 0, K_AGI = 1, K_SPIN = 2, K_BRAKE = 3, K_HOLD = 4, K_FAULT = 5;
  int mk, mdir, mleft, mbrake, mplan, mplan_dir, mmode, mspin, mramp, pcnt;
  int mpwm;

  task automatic go_agi(input int d);
    mk = K_AGI; mdir = d; mleft = 8;
  endtask
  task automatic go_spin();
    mk = K_SPIN; mspin = 64; mramp = 4;
  endtask
  task automatic go_brake(input int plan, input int pdir);
    mk = K_BRAKE; mbrake = 3; mplan = plan; mplan_dir = pdir;
  endtask

  task automatic model_outs(output int en, output int dir, output int duty, output int busy,
                            output int rdy, output int flt);
    en   = (mk == K_AGI || mk == K_SPIN) ? 1 : 0;
    dir  = (mk == K_AGI) ? ((mdir > 0) ? 1 : 2) : ((mk == K_SPIN) ? 1 : 0);
    duty = (mk == K_AGI) ? ((mmode == 2) ? 192 : 96) : ((mk == K_SPIN) ? mspin : 0);
    busy = (mk != K_IDLE) ? 1 : 0;
    rdy  = (mk != K_BRAKE) ? 1 : 0;
    flt  = (mk == K_FAULT) ? 1 : 0;
  endtask

  task automatic model_step(input bit v, input int m, input bit door, input bit pz, input bit r);
    int en0, dir0, duty0, busy0, rdy0, flt0;
    bit acc;
    model_outs(en0, dir0, duty0, busy0, rdy0, flt0);
    acc = v && (rdy0 == 1);
    if (r) begin
      mk = K_IDLE; mmode = 0; mbrake = 0; mspin = 0; pcnt = 0; mpwm = 0;
    end else begin
      mpwm = (en0 == 1 && pcnt < duty0) ? 1 : 0;
      pcnt = (pcnt + 1) % 256;
      if (!door && mk != K_IDLE && mk != K_FAULT) begin
        mk = K_FAULT;
      end else begin
        case (mk)
          K_IDLE: if (acc && door) begin
            mmode = m;
            if (m == 1 || m == 2) go_agi(1);
            else if (m == 3) go_spin();
          end
          K_AGI: begin
            if (pz) go_brake(K_HOLD, 0);
            else if (acc && (m == 0 || m == 3)) begin
              mmode = m;
              go_brake((m == 3) ? K_SPIN : K_IDLE, 1);
            end else begin
              if (acc) mmode = m;
              mleft--;
              if (mleft == 0) go_brake(K_AGI, -mdir);
            end
          end
          K_SPIN: begin
            if (pz) go_brake(K_HOLD, 0);
            else if (acc && m != 3) begin
              mmode = m;
              go_brake((m == 0) ? K_IDLE : K_AGI, 1);
            end else begin
              mramp--;
              if (mramp == 0) begin
                mspin = (mspin + 64 > 255) ? 255 : mspin + 64;
                mramp = 4;
              end
            end
          end
          K_BRAKE: begin
            mbrake--;
            if (mbrake == 0) begin
              if (mplan == K_AGI) go_agi(mplan_dir);
              else if (mplan == K_SPIN) go_spin();
              else mk = mplan;
            end
          end
          K_HOLD: begin
            if (acc) mmode = m;
            if (!pz) begin
              if (mmode == 1 || mmode == 2) go_agi(1);
              else if (mmode == 3) go_spin();
              else mk = K_IDLE;
            end
          end
          default: if (acc && m == 0 && door) begin
            mk = K_IDLE; mmode = 0;
          end
        endcase
      end
    end
  endtask

  initial begin
    int e_en, e_dir, e_duty, e_busy, e_rdy, e_flt;
    bit rv, rdoor, rpz, rr;
    int rm;

    // Agitate HI: CW 8, dead 3, CCW 8, dead 3, CW.
    add(0, 2'd0, 1, 0, 1, 0, 0, 0, 0, 1, 0);
    add(1, 2'd2, 1, 0, 0, 1, 1, 192, 1, 1, 0);
    for (int k = 0; k < 7; k++) add(0, 2'd0, 1, 0, 0, 1, 1, 192, 1, 1, 0);
    for (int k = 0; k < 3; k++) add(0, 2'd0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 8; k++) add(0, 2'd0, 1, 0, 0, 1, 2, 192, 1, 1, 0);
    for (int k = 0; k < 3; k++) add(0, 2'd0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 2'd0, 1, 0, 0, 1, 1, 192, 1, 1, 0);
    // Spin ramp: 64, 128, 192 for 4 clocks each, then held at 255.
    add(0, 2'd0, 1, 0, 1, 0, 0, 0, 0, 1, 0);
    add(1, 2'd3, 1, 0, 0, 1, 1, 64, 1, 1, 0);
    for (int k = 0; k < 3; k++) add(0, 2'd0, 1, 0, 0, 1, 1, 64, 1, 1, 0);
    for (int k = 0; k < 4; k++) add(0, 2'd0, 1, 0, 0, 1, 1, 128, 1, 1, 0);
    for (int k = 0; k < 4; k++) add(0, 2'd0, 1, 0, 0, 1, 1, 192, 1, 1, 0);
    for (int k = 0; k < 6; k++) add(0, 2'd0, 1, 0, 0, 1, 1, 255, 1, 1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].v, tbl[i].m, tbl[i].door, tbl[i].pz, tbl[i].r);
      chk_all($sformatf("vec%0d", i), tbl[i].en, tbl[i].dir, tbl[i].duty,
              tbl[i].busy, tbl[i].rdy, tbl[i].flt);
    end

    // STOP mid CW run; commands offered during the dead time are refused.
    cyc(0, 2'd0, 1, 0, 1);
    chk(  "stop.rst_pwm", 32'(bus.pwm_out), 0);
    cyc(1, 2'd1, 1, 0, 0); chk_all("stop.run", 1, 1, 96, 1, 1, 0);
    cyc(0, 2'd0, 1, 0, 0);
    cyc(0, 2'd0, 1, 0, 0);
    cyc(1, 2'd0, 1, 0, 0); chk_all("stop.brk1", 0, 0, 0, 1, 0, 0);
    cyc(1, 2'd2, 1, 0, 0); chk_all("stop.brk2", 0, 0, 0, 1, 0, 0);
    cyc(1, 2'd2, 1, 0, 0); chk_all("stop.brk3", 0, 0, 0, 1, 0, 0);
    cyc(0, 2'd0, 1, 0, 0); chk_all("stop.idle", 0, 0, 0, 0, 1, 0);
    cyc(0, 2'd0, 1, 0, 0); chk_all("stop.idle2", 0, 0, 0, 0, 1, 0);

    // Pause at clock 5 of spin, hold, resume with the ramp restarted.
    cyc(0, 2'd0, 1, 0, 1);
    cyc(1, 2'd3, 1, 0, 0); chk_all("pz.spin", 1, 1, 64, 1, 1, 0);
    for (int k = 0; k < 3; k++) cyc(0, 2'd0, 1, 0, 0);
    cyc(0, 2'd0, 1, 1, 0); chk_all("pz.brk1", 0, 0, 0, 1, 0, 0);
    cyc(0, 2'd0, 1, 1, 0);
    cyc(0, 2'd0, 1, 1, 0); chk_all("pz.brk3", 0, 0, 0, 1, 0, 0);
    cyc(0, 2'd0, 1, 1, 0); chk_all("pz.hold", 0, 0, 0, 1, 1, 0);
    cyc(0, 2'd0, 1, 1, 0); chk_all("pz.hold2", 0, 0, 0, 1, 1, 0);
    cyc(0, 2'd0, 1, 0, 0); chk_all("pz.resume", 1, 1, 64, 1, 1, 0);

    // Door opens during CCW run; only STOP with the door latched clears the fault.
    cyc(0, 2'd0, 1, 0, 1);
    cyc(1, 2'd1, 1, 0, 0);
    for (int k = 0; k < 10; k++) cyc(0, 2'd0, 1, 0, 0);
    cyc(0, 2'd0, 1, 0, 0); chk_all("door.ccw", 1, 2, 96, 1, 1, 0);
    cyc(0, 2'd0, 1, 0, 0);
    cyc(0, 2'd0, 0, 0, 0); chk_all("door.fault", 0, 0, 0, 1, 1, 1);
    cyc(1, 2'd1, 1, 0, 0); chk_all("door.agi_drop", 0, 0, 0, 1, 1, 1);
    cyc(1, 2'd0, 0, 0, 0); chk_all("door.stop_open", 0, 0, 0, 1, 1, 1);
    cyc(1, 2'd0, 1, 0, 0); chk_all("door.clear", 0, 0, 0, 0, 1, 0);
    cyc(1, 2'd2, 0, 0, 0); chk_all("door.idle_drop", 0, 0, 0, 0, 1, 0);
    cyc(0, 2'd0, 1, 0, 0); chk_all("door.idle2", 0, 0, 0, 0, 1, 0);

    // Reset while spinning at duty 192.
    cyc(0, 2'd0, 1, 0, 1);
    cyc(1, 2'd3, 1, 0, 0);
    for (int k = 0; k < 8; k++) cyc(0, 2'd0, 1, 0, 0);
    chk_all("rst.d192", 1, 1, 192, 1, 1, 0);
    cyc(0, 2'd0, 1, 0, 1); chk_all("rst.after", 0, 0, 0, 0, 1, 0);
    chk("rst.pwm", 32'(bus.pwm_out), 0);

    // Random stimulus against the behavioural model.
    rdoor = 1; rpz = 0;
    cyc(0, 2'd0, 1, 0, 1);
    model_step(0, 0, 1, 0, 1);
    for (int i = 0; i < 4000; i++) begin
      rv = ($urandom_range(0, 5) == 0);
      rm = int'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) rpz = !rpz;
      if (rdoor) rdoor = ($urandom_range(0, 149) != 0);
      else       rdoor = ($urandom_range(0, 4) == 0);
      rr = ($urandom_range(0, 499) == 0);
      cyc(rv, 2'(rm), rdoor, rpz, rr);
      model_step(rv, rm, rdoor, rpz, rr);
      model_outs(e_en, e_dir, e_duty, e_busy, e_rdy, e_flt);
      chk_all($sformatf("rnd%0d", i), e_en, e_dir, e_duty, e_busy, e_rdy, e_flt);
      chk($sformatf("rnd%0d.pwm", i), 32'(bus.pwm_out), mpwm);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
